// File: rtl/mem_pkg.sv
// Purpose : shared types and constants for the MEM stage and its SRAM controller.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   mem_state_e   - SRAM access sequencer states
//   BASE_ADDR_DEF - byte address that maps onto SRAM word 0
//   HALF_LO/HI    - half-word select appended to the SRAM word address
//   CNT_W         - width of the wait-state counter (WAIT_CYCLES up to 15)
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam int unsigned BASE_ADDR_DEF = 1024;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam int CNT_W = 4;

    // A memory request is any load or store; a load+store combination
    // still counts as a single access.
    function automatic logic is_mem_req(input logic rd_en, input logic wr_en);
        return rd_en | wr_en;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Purpose : sequences one 32-bit load/store as two 16-bit SRAM accesses (low half, then high half).
// Latency : 1 + 2*WAIT_CYCLES stall cycles per access, then one DONE cycle where the word is valid.
// Backpressure: ready_o low from the request cycle until the high half completes; inputs must be held.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   rd_en_i/wr_en_i - load / store request (both set = store, read data unused)
//   addr_i          - byte address of the access
//   wdata_i         - store data
//   ready_o         - 0 while the access is in flight
//   rword_o         - assembled read word, valid in DONE
//   sram_*          - SRAM pins (half-word address, write data, read data, WE_N, bus drive enable)
module sram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en_i,
    input  logic               wr_en_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic               ready_o,
    output logic [31:0]        rword_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [15:0]        sram_wdata_o,
    input  logic [15:0]        sram_rdata_i,
    output logic               sram_we_n_o,
    output logic               sram_dq_oe_o
);

    localparam int            WORD_W   = SRAM_AW - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    mem_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic [15:0]        rlo_q, rlo_d;
    logic [15:0]        rhi_q, rhi_d;

    logic               req;
    logic               last_cyc;
    logic               in_access;
    logic [31:0]        offset;
    logic               unused_addr_bits;

    assign req      = is_mem_req(rd_en_i, wr_en_i);
    assign last_cyc = (cnt_q == LAST_CNT);
    assign offset   = addr_i - 32'(BASE_ADDR);

    // Byte-within-word bits and bits above the SRAM range are dropped.
    assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    //------------------------------------------------------------------
    // State register and latches
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rlo_q   <= '0;
            rhi_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rlo_q   <= rlo_d;
            rhi_q   <= rhi_d;
        end
    end

    //------------------------------------------------------------------
    // Next-state logic and ready
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rlo_d   = rlo_q;
        rhi_d   = rhi_q;
        ready_o = 1'b1;

        case (state_q)
            IDLE: begin
                if (req) begin
                    // Freeze upstream in the same cycle the request appears,
                    // so the instruction cannot slip past us.
                    ready_o = 1'b0;
                    state_d = LO;
                    cnt_d   = '0;
                    word_d  = offset[SRAM_AW:2];
                    wdata_d = wdata_i;
                    wr_d    = wr_en_i;
                end
            end
            LO: begin
                ready_o = 1'b0;
                if (last_cyc) begin
                    if (!wr_q) begin
                        rlo_d = sram_rdata_i;
                    end
                    state_d = HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HI: begin
                ready_o = 1'b0;
                if (last_cyc) begin
                    if (!wr_q) begin
                        rhi_d = sram_rdata_i;
                    end
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // One cycle with ready high lets the MEM/WB register take
                // the result; the next request is seen back in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // SRAM pins: decoded from registered state only, so an asynchronous
    // reset releases the bus immediately.
    //------------------------------------------------------------------
    assign in_access    = (state_q == LO) || (state_q == HI);
    assign sram_we_n_o  = ~(wr_q & in_access);
    assign sram_dq_oe_o = wr_q & in_access;
    assign sram_addr_o  = {word_q, (state_q == HI) ? HALF_HI : HALF_LO};
    assign sram_wdata_o = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign rword_o      = {rhi_q, rlo_q};

endmodule

// File: rtl/mem_stage.sv
// Purpose : ARM pipeline MEM stage; runs loads/stores through the SRAM controller and holds the MEM/WB register.
// Latency : non-memory ops reach MEM/WB in 1 cycle; memory ops after 1 + 2*WAIT_CYCLES stall cycles.
// Backpressure: ready low freezes PC, IF/ID/EX and EXE/MEM; MEM/WB takes bubbles while frozen.
//
// Ports:
//   clk, rst                               - clock, asynchronous active-high reset
//   WB_en_in, MEM_R_EN_in, MEM_W_EN_in     - control from EXE/MEM
//   ALU_result_in, val_Rm_in, Dest_in      - address/result, store data, destination
//   ready                                  - 0 = upstream frozen
//   WB_en, MEM_R_EN, ALU_result, mem_data, Dest - MEM/WB register
//   SRAM_*                                 - external 16-bit SRAM interface
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               WB_en_in,
    input  logic               MEM_R_EN_in,
    input  logic               MEM_W_EN_in,
    input  logic [31:0]        ALU_result_in,
    input  logic [31:0]        val_Rm_in,
    input  logic [3:0]         Dest_in,
    output logic               ready,
    output logic               WB_en,
    output logic               MEM_R_EN,
    output logic [31:0]        ALU_result,
    output logic [31:0]        mem_data,
    output logic [3:0]         Dest,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_WDATA,
    input  logic [15:0]        SRAM_RDATA,
    output logic               SRAM_WE_N,
    output logic               SRAM_DQ_OE
);

    logic [31:0] rword;
    logic        is_load;

    logic        wb_en_q,      wb_en_d;
    logic        mem_r_en_q,   mem_r_en_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] mem_data_q,   mem_data_d;
    logic [3:0]  dest_q,       dest_d;

    sram_ctrl #(
        .BASE_ADDR   (BASE_ADDR),
        .WAIT_CYCLES (WAIT_CYCLES),
        .SRAM_AW     (SRAM_AW)
    ) u_sram_ctrl (
        .clk          (clk),
        .rst          (rst),
        .rd_en_i      (MEM_R_EN_in),
        .wr_en_i      (MEM_W_EN_in),
        .addr_i       (ALU_result_in),
        .wdata_i      (val_Rm_in),
        .ready_o      (ready),
        .rword_o      (rword),
        .sram_addr_o  (SRAM_ADDR),
        .sram_wdata_o (SRAM_WDATA),
        .sram_rdata_i (SRAM_RDATA),
        .sram_we_n_o  (SRAM_WE_N),
        .sram_dq_oe_o (SRAM_DQ_OE)
    );

    // A load+store combination performs the write only, so it returns no data.
    assign is_load = MEM_R_EN_in & ~MEM_W_EN_in;

    //------------------------------------------------------------------
    // MEM/WB register: a frozen cycle becomes a bubble so every
    // instruction produces exactly one writeback slot.
    //------------------------------------------------------------------
    always_comb begin
        wb_en_d      = 1'b0;
        mem_r_en_d   = 1'b0;
        alu_result_d = '0;
        mem_data_d   = '0;
        dest_d       = '0;
        if (ready) begin
            wb_en_d      = WB_en_in;
            mem_r_en_d   = MEM_R_EN_in;
            alu_result_d = ALU_result_in;
            mem_data_d   = is_load ? rword : 32'h0;
            dest_d       = Dest_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            dest_q       <= '0;
        end else begin
            wb_en_q      <= wb_en_d;
            mem_r_en_q   <= mem_r_en_d;
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
            dest_q       <= dest_d;
        end
    end

    assign WB_en      = wb_en_q;
    assign MEM_R_EN   = mem_r_en_q;
    assign ALU_result = alu_result_q;
    assign mem_data   = mem_data_q;
    assign Dest       = dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// Purpose : self-checking bench for mem_stage with a behavioural SRAM and a per-cycle MEM/WB model.
// Latency : n/a.
// Backpressure: the driver acts as the frozen upstream, holding inputs while ready is low.
module tb_mem_stage;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] ALU_result_in, val_Rm_in;
    logic [3:0]  Dest_in;
    logic        ready, WB_en, MEM_R_EN;
    logic [31:0] ALU_result, mem_data;
    logic [3:0]  Dest;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_WDATA, SRAM_RDATA;
    logic        SRAM_WE_N, SRAM_DQ_OE;

    always #5 clk = ~clk;

    mem_stage #(.BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst),
        .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .ALU_result_in(ALU_result_in), .val_Rm_in(val_Rm_in), .Dest_in(Dest_in),
        .ready(ready), .WB_en(WB_en), .MEM_R_EN(MEM_R_EN),
        .ALU_result(ALU_result), .mem_data(mem_data), .Dest(Dest),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA), .SRAM_RDATA(SRAM_RDATA),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_DQ_OE(SRAM_DQ_OE)
    );

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] md;
        logic [3:0]  dest;
    } wbrec_t;

    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    wbrec_t      expq[$];
    wr_t         wlog[$];
    int unsigned model_words[int];
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    logic [15:0] sram [0:63];

    // Behavioural SRAM: asynchronous read, write mid-cycle while WE_N is low.
    assign SRAM_RDATA = sram[SRAM_ADDR[5:0]];

    initial begin
        for (int i = 0; i < 64; i++) sram[i] = 16'h0;
        sram[8] = 16'hF00D;
        sram[9] = 16'hCAFE;
        forever begin
            @(negedge clk);
            if (!SRAM_WE_N) sram[SRAM_ADDR[5:0]] = SRAM_WDATA;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of MEM/WB against the model stream; idle cycles expect zeros.
    always @(posedge clk) begin
        wbrec_t e;
        #2;
        if (!SRAM_WE_N) wlog.push_back({SRAM_ADDR, SRAM_WDATA});
        if (chk_en) begin
            e = (expq.size() > 0) ? expq.pop_front() : '0;
            chk("mw_WB_en",      {31'h0, WB_en},    {31'h0, e.wb});
            chk("mw_MEM_R_EN",   {31'h0, MEM_R_EN}, {31'h0, e.mr});
            chk("mw_ALU_result", ALU_result,        e.alu);
            chk("mw_mem_data",   mem_data,          e.md);
            chk("mw_Dest",       {28'h0, Dest},     {28'h0, e.dest});
            chk("pin_oe_vs_we",  {31'h0, SRAM_DQ_OE}, {31'h0, ~SRAM_WE_N});
            chk("pin_addr_range", {14'h0, SRAM_ADDR[17:6]}, 32'h0);
        end
    end

    // Present one instruction, hold it while frozen, return at the negedge after it is taken.
    task automatic issue(input logic wb, input logic r, input logic w,
                         input logic [31:0] alu, input logic [31:0] rm,
                         input logic [3:0] dest, output int stalls);
        wbrec_t res;
        int     exp_stall;
        int     widx;
        WB_en_in      = wb;
        MEM_R_EN_in   = r;
        MEM_W_EN_in   = w;
        ALU_result_in = alu;
        val_Rm_in     = rm;
        Dest_in       = dest;

        exp_stall = (r || w) ? 1 + 2 * W : 0;
        widx      = int'((alu - 32'd1024) >> 2);
        res.wb    = wb;
        res.mr    = r;
        res.alu   = alu;
        res.dest  = dest;
        res.md    = (r && !w) ? model_words[widx] : 32'h0;
        if (w) model_words[widx] = rm;
        for (int i = 0; i < exp_stall; i++) expq.push_back('0);
        expq.push_back(res);

        stalls = 0;
        #1;
        while (!ready && stalls < 50) begin
            @(posedge clk);
            stalls++;
            @(negedge clk);
            #1;
        end
        if (!ready) chk("ready_timeout", {31'h0, ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("stall_len", stalls, exp_stall);
    endtask

    task automatic idle();
        WB_en_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0;
        ALU_result_in = 0; val_Rm_in = 0; Dest_in = 0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int n;
        WB_en_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0;
        ALU_result_in = 0; val_Rm_in = 0; Dest_in = 0;
        model_words[4] = 32'hCAFEF00D;

        #1 rst = 1'b1;
        #2;
        chk("rst_WB_en",      {31'h0, WB_en}, 0);
        chk("rst_MEM_R_EN",   {31'h0, MEM_R_EN}, 0);
        chk("rst_ALU_result", ALU_result, 0);
        chk("rst_mem_data",   mem_data, 0);
        chk("rst_Dest",       {28'h0, Dest}, 0);
        chk("rst_WE_N",       {31'h0, SRAM_WE_N}, 1);
        chk("rst_DQ_OE",      {31'h0, SRAM_DQ_OE}, 0);
        chk("rst_ADDR",       {14'h0, SRAM_ADDR}, 0);
        chk("rst_WDATA",      {16'h0, SRAM_WDATA}, 0);
        chk("rst_ready",      {31'h0, ready}, 1);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // ALU op: no stall, no SRAM write
        wlog.delete();
        issue(1, 0, 0, 32'h7, 32'h0, 4'd3, st);
        chk("alu_stall", st, 0);
        chk("alu_WB_en", {31'h0, WB_en}, 1);
        chk("alu_result", ALU_result, 32'h7);
        chk("alu_Dest", {28'h0, Dest}, 3);
        chk("alu_mem_data", mem_data, 0);
        chk("alu_no_write", wlog.size(), 0);
        idle();

        // Store 0xDEADBEEF to 0x408 -> half-words 4, 5
        wlog.delete();
        issue(0, 0, 1, 32'h408, 32'hDEADBEEF, 4'd5, st);
        chk("st_stall", st, 5);
        chk("st_wcycles", wlog.size(), 4);
        if (wlog.size() == 4) begin
            chk("st_w0", {wlog[0].a, wlog[0].d}, {18'd4, 16'hBEEF});
            chk("st_w1", {wlog[1].a, wlog[1].d}, {18'd4, 16'hBEEF});
            chk("st_w2", {wlog[2].a, wlog[2].d}, {18'd5, 16'hDEAD});
            chk("st_w3", {wlog[3].a, wlog[3].d}, {18'd5, 16'hDEAD});
        end
        chk("st_sram4", {16'h0, sram[4]}, 32'hBEEF);
        chk("st_sram5", {16'h0, sram[5]}, 32'hDEAD);
        idle();

        // Load 0x408 immediately followed by an ALU op
        issue(1, 1, 0, 32'h408, 32'h0, 4'd2, st);
        chk("ld_stall", st, 5);
        chk("ld_mem_data", mem_data, 32'hDEADBEEF);
        chk("ld_MEM_R_EN", {31'h0, MEM_R_EN}, 1);
        chk("ld_WB_en", {31'h0, WB_en}, 1);
        issue(1, 0, 0, 32'h55, 32'h0, 4'd4, st);
        chk("ld_alu_stall", st, 0);
        chk("ld_alu_result", ALU_result, 32'h55);
        chk("ld_alu_mem_data", mem_data, 0);
        idle();

        // Load of a word preloaded in SRAM
        issue(1, 1, 0, 32'h410, 32'h0, 4'd6, st);
        chk("pre_mem_data", mem_data, 32'hCAFEF00D);
        idle();

        // Load+store at 0x40C: write happens, no read data
        wlog.delete();
        issue(1, 1, 1, 32'h40C, 32'h12345678, 4'd7, st);
        chk("rw_stall", st, 5);
        chk("rw_mem_data", mem_data, 0);
        chk("rw_MEM_R_EN", {31'h0, MEM_R_EN}, 1);
        chk("rw_sram6", {16'h0, sram[6]}, 32'h5678);
        chk("rw_sram7", {16'h0, sram[7]}, 32'h1234);
        chk("rw_wcycles", wlog.size(), 4);

        // Back-to-back store then load, no idle gap
        issue(0, 0, 1, 32'h414, 32'hA5A55A5A, 4'd0, st);
        issue(1, 1, 0, 32'h414, 32'h0, 4'd8, st);
        chk("b2b_stall", st, 5);
        chk("b2b_mem_data", mem_data, 32'hA5A55A5A);
        idle();

        // Reset in the second HI cycle of a store, request held across release
        chk_en        = 1'b0;
        WB_en_in      = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 1;
        ALU_result_in = 32'h408; val_Rm_in = 32'h11112222; Dest_in = 4'd1;
        repeat (4) @(posedge clk);
        #2;
        chk("rst_mid_addr_pre", {14'h0, SRAM_ADDR}, 5);
        chk("rst_mid_we_pre", {31'h0, SRAM_WE_N}, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", {31'h0, SRAM_WE_N}, 1);
        chk("rst_mid_oe", {31'h0, SRAM_DQ_OE}, 0);
        chk("rst_mid_addr", {14'h0, SRAM_ADDR}, 0);
        chk("rst_mid_wdata", {16'h0, SRAM_WDATA}, 0);
        chk("rst_mid_WB_en", {31'h0, WB_en}, 0);
        chk("rst_mid_ALU", ALU_result, 0);
        chk("rst_mid_ready", {31'h0, ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_restart_addr", {14'h0, SRAM_ADDR}, 4);
        chk("rst_restart_we", {31'h0, SRAM_WE_N}, 0);
        chk("rst_restart_wdata", {16'h0, SRAM_WDATA}, 32'h2222);
        n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_restart_ready", {31'h0, ready}, 1);
        @(posedge clk);
        @(negedge clk);
        model_words[2] = 32'h11112222;
        WB_en_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0;
        ALU_result_in = 0; val_Rm_in = 0; Dest_in = 0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_after_sram4", {16'h0, sram[4]}, 32'h2222);
        chk("rst_after_sram5", {16'h0, sram[5]}, 32'h1111);

        issue(1, 1, 0, 32'h408, 32'h0, 4'd9, st);
        chk("rst_after_load", mem_data, 32'h11112222);
        idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
